// File: rtl/cache_mem_port_if.sv
// Bundle of the cache-side request/response handshake and the memory-side
// valid/ready word bus used by cache_mem_port.
//
// Signals:
//   req_valid/req_ready/req_write/req_line_addr/req_wdata : line request from cache
//   resp_valid/resp_write/resp_err/resp_rdata              : one-cycle completion
//   mem_valid/mem_ready/mem_we/mem_addr/mem_wdata          : word command channel
//   mem_rvalid/mem_rdata                                   : word read-return channel
//
// Modports:
//   slave  : the port block itself (accepts requests, issues memory commands)
//   master : the environment (cache requester plus memory responder)
interface cache_mem_port_if #(
    parameter int unsigned ADDR_WIDTH      = 22,
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned BLOCK_SIZE      = 8,
    parameter int unsigned LINE_ADDR_WIDTH = 17
);
    logic                            req_valid;
    logic                            req_ready;
    logic                            req_write;
    logic [LINE_ADDR_WIDTH-1:0]      req_line_addr;
    logic [WORD_SIZE*BLOCK_SIZE-1:0] req_wdata;

    logic                            resp_valid;
    logic                            resp_write;
    logic                            resp_err;
    logic [WORD_SIZE*BLOCK_SIZE-1:0] resp_rdata;

    logic                            mem_valid;
    logic                            mem_ready;
    logic                            mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [WORD_SIZE-1:0]            mem_wdata;
    logic                            mem_rvalid;
    logic [WORD_SIZE-1:0]            mem_rdata;

    modport slave (
        input  req_valid, req_write, req_line_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_write, resp_err, resp_rdata,
        output mem_valid, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output req_valid, req_write, req_line_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_write, resp_err, resp_rdata,
        input  mem_valid, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/cache_mem_port.sv
// Memory-side port of the direct-mapped cache. Turns one whole-line refill or
// writeback request into a word-serial burst of BLOCK_SIZE single-word
// transactions on a valid/ready memory bus, then returns the assembled line
// (or a completion) in a single resp_valid pulse. A per-word timeout aborts a
// stuck burst and flags resp_err.
//
// Ports:
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus_io : cache_mem_port_if.slave -- request, response and memory buses
module cache_mem_port #(
    parameter int unsigned ADDR_WIDTH      = 22,
    parameter int unsigned WORD_SIZE       = 32,
    parameter int unsigned BLOCK_SIZE      = 8,
    parameter int unsigned LINE_ADDR_WIDTH = 17,
    parameter int unsigned TIMEOUT_CYCLES  = 255
) (
    input  logic            clk,
    input  logic            resetn,
    cache_mem_port_if.slave bus_io
);
    localparam int unsigned LineW = WORD_SIZE * BLOCK_SIZE;
    localparam int unsigned BeatW = $clog2(BLOCK_SIZE);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BeatW-1:0] LastBeat = BeatW'(BLOCK_SIZE - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StRdata, StDone} state_e;

    state_e                     state_q;
    logic [BeatW-1:0]           beat_q;
    logic [TmoW-1:0]            timeout_q;
    logic                       write_q;
    logic [LINE_ADDR_WIDTH-1:0] line_addr_q;
    logic [LineW-1:0]           wdata_q;

    logic                       mem_valid_q;
    logic                       mem_we_q;
    logic [ADDR_WIDTH-1:0]      mem_addr_q;
    logic [WORD_SIZE-1:0]       mem_wdata_q;

    logic                       resp_valid_q;
    logic                       resp_write_q;
    logic                       resp_err_q;
    logic [LineW-1:0]           resp_rdata_q;

    logic [BeatW-1:0]           beat_nxt;

    assign beat_nxt = beat_q + 1'b1;

    // Word byte address: line-aligned base plus word offset, byte bits zero.
    function automatic logic [ADDR_WIDTH-1:0] word_addr(
        input logic [LINE_ADDR_WIDTH-1:0] line,
        input logic [BeatW-1:0]           beat
    );
        return ADDR_WIDTH'({line, beat, 2'b00});
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            timeout_q    <= '0;
            write_q      <= 1'b0;
            line_addr_q  <= '0;
            wdata_q      <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_write_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            // Response is a single-cycle pulse asserted only while in StDone.
            resp_valid_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    timeout_q <= '0;
                    if (bus_io.req_valid) begin
                        write_q      <= bus_io.req_write;
                        line_addr_q  <= bus_io.req_line_addr;
                        wdata_q      <= bus_io.req_wdata;
                        beat_q       <= '0;
                        resp_rdata_q <= '0;
                        resp_write_q <= bus_io.req_write;
                        resp_err_q   <= 1'b0;
                        mem_valid_q  <= 1'b1;
                        mem_we_q     <= bus_io.req_write;
                        mem_addr_q   <= word_addr(bus_io.req_line_addr, '0);
                        mem_wdata_q  <= bus_io.req_write ?
                                        bus_io.req_wdata[WORD_SIZE-1:0] : '0;
                        state_q      <= StCmd;
                    end
                end

                StCmd: begin
                    if (bus_io.mem_ready) begin
                        timeout_q <= '0;
                        if (!write_q) begin
                            mem_valid_q <= 1'b0;
                            state_q     <= StRdata;
                        end else if (beat_q == LastBeat) begin
                            mem_valid_q  <= 1'b0;
                            resp_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            // Present the next write word directly; no idle gap.
                            beat_q      <= beat_nxt;
                            mem_addr_q  <= word_addr(line_addr_q, beat_nxt);
                            mem_wdata_q <= wdata_q[WORD_SIZE*beat_nxt +: WORD_SIZE];
                        end
                    end else if (timeout_q == TmoLast) begin
                        timeout_q    <= '0;
                        mem_valid_q  <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        timeout_q <= timeout_q + 1'b1;
                    end
                end

                StRdata: begin
                    if (bus_io.mem_rvalid) begin
                        timeout_q <= '0;
                        resp_rdata_q[WORD_SIZE*beat_q +: WORD_SIZE] <= bus_io.mem_rdata;
                        if (beat_q == LastBeat) begin
                            resp_valid_q <= 1'b1;
                            state_q      <= StDone;
                        end else begin
                            beat_q      <= beat_nxt;
                            mem_valid_q <= 1'b1;
                            mem_addr_q  <= word_addr(line_addr_q, beat_nxt);
                            state_q     <= StCmd;
                        end
                    end else if (timeout_q == TmoLast) begin
                        // Words not yet received stay zero in resp_rdata.
                        timeout_q    <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= StDone;
                    end else begin
                        timeout_q <= timeout_q + 1'b1;
                    end
                end

                StDone: begin
                    timeout_q <= '0;
                    state_q   <= StIdle;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus_io.req_ready  = (state_q == StIdle);
    assign bus_io.resp_valid = resp_valid_q;
    assign bus_io.resp_write = resp_write_q;
    assign bus_io.resp_err   = resp_err_q;
    assign bus_io.resp_rdata = resp_rdata_q;
    assign bus_io.mem_valid  = mem_valid_q;
    assign bus_io.mem_we     = mem_we_q;
    assign bus_io.mem_addr   = mem_addr_q;
    assign bus_io.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_cache_mem_port.sv
// Scoreboard bench for cache_mem_port: expected memory commands and responses
// are queued when a request is issued; a monitor pops and compares them as the
// DUT presents handshakes and resp_valid pulses. A small memory model answers
// reads with 0xA0000000|addr and can stall, drop a read, or emit stray rvalid.
module tb_cache_mem_port;
    localparam int unsigned Tmo = 16;

    typedef struct packed {
        logic        we;
        logic [21:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic         write;
        logic         err;
        logic [255:0] rdata;
        int           lat;
    } resp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    cache_mem_port_if bus ();

    cache_mem_port #(.TIMEOUT_CYCLES(Tmo)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int resp_seen = 0;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];

    // Memory model configuration
    bit       cfg_stall = 0;
    bit [2:0] cfg_stall_beat = 0;
    int       cfg_stall_len = 0;
    int       stall_done = 0;
    bit       cfg_drop = 0;
    bit [2:0] cfg_drop_beat = 0;
    bit       cfg_stray = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected event expected none", name);
    endtask

    function automatic logic [255:0] model_line(input logic [16:0] line, input int nwords);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < nwords; k++)
            r[32*k +: 32] = 32'hA000_0000 | {10'd0, line, 3'(k), 2'b00};
        return r;
    endfunction

    // Memory responder: decide each cycle's ready/rvalid at posedge+1.
    initial begin
        logic        hs;
        logic        hs_we;
        logic [21:0] hs_addr;
        bus.mem_ready  = 1'b1;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clk);
            hs      = bus.mem_valid && bus.mem_ready;
            hs_we   = bus.mem_we;
            hs_addr = bus.mem_addr;
            @(posedge clk);
            #1;
            if (hs && !hs_we && !(cfg_drop && hs_addr[4:2] == cfg_drop_beat)) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hA000_0000 | {10'd0, hs_addr};
            end else if (cfg_stray) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hDEAD_BEEF;
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = '0;
            end
            if (cfg_stall && bus.mem_valid && bus.mem_addr[4:2] == cfg_stall_beat &&
                stall_done < cfg_stall_len) begin
                bus.mem_ready = 1'b0;
                stall_done++;
            end else begin
                bus.mem_ready = 1'b1;
            end
        end
    end

    // Monitor: compares every command handshake and response against the queues.
    initial begin
        cmd_t        c;
        resp_t       r;
        logic        prev_stall;
        logic [21:0] prev_addr;
        logic [31:0] prev_wdata;
        prev_stall = 1'b0;
        prev_addr  = '0;
        prev_wdata = '0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (prev_stall) begin
                    check("stall_valid_held", bus.mem_valid, 1'b1);
                    check("stall_addr_stable", bus.mem_addr, prev_addr);
                    check("stall_wdata_stable", bus.mem_wdata, prev_wdata);
                end
                prev_stall = bus.mem_valid && !bus.mem_ready;
                prev_addr  = bus.mem_addr;
                prev_wdata = bus.mem_wdata;
                if (bus.mem_valid && bus.mem_ready) begin
                    if (cmd_q.size() == 0) begin
                        fail("unexpected_cmd");
                    end else begin
                        c = cmd_q.pop_front();
                        check("cmd_we", bus.mem_we, c.we);
                        check("cmd_addr", bus.mem_addr, c.addr);
                        check("cmd_wdata", bus.mem_wdata, c.wdata);
                    end
                end
                if (bus.resp_valid) begin
                    resp_seen++;
                    if (resp_q.size() == 0) begin
                        fail("unexpected_resp");
                    end else begin
                        r = resp_q.pop_front();
                        check("resp_write", bus.resp_write, r.write);
                        check("resp_err", bus.resp_err, r.err);
                        check("resp_rdata", bus.resp_rdata, r.rdata);
                        if (r.lat >= 0) check("resp_latency", 256'(cyc - accept_cyc), 256'(r.lat));
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic issue(input bit we, input logic [16:0] line, input logic [255:0] wd,
                         input int ncmd, input bit push_resp, input bit exp_err,
                         input logic [255:0] exp_rdata, input int exp_lat);
        cmd_t  c;
        resp_t r;
        bit    accepted;
        for (int k = 0; k < ncmd; k++) begin
            c.we    = we;
            c.addr  = {line, 3'(k), 2'b00};
            c.wdata = we ? wd[32*k +: 32] : 32'd0;
            cmd_q.push_back(c);
        end
        if (push_resp) begin
            r.write = we;
            r.err   = exp_err;
            r.rdata = exp_rdata;
            r.lat   = exp_lat;
            resp_q.push_back(r);
        end
        @(posedge clk);
        #1;
        bus.req_valid     = 1'b1;
        bus.req_write     = we;
        bus.req_line_addr = line;
        bus.req_wdata     = wd;
        accepted = 0;
        for (int n = 0; n < 50 && !accepted; n++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                accepted   = 1;
                accept_cyc = cyc;
            end
        end
        if (!accepted) fail("req_accept");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int target, input string name);
        bit got;
        got = 0;
        for (int n = 0; n < 200 && !got; n++) begin
            @(negedge clk);
            if (resp_seen >= target) got = 1;
        end
        if (!got) fail(name);
    endtask

    initial begin
        logic [255:0] rd;
        logic [255:0] wd;
        bit           found;
        int           n0;

        bus.req_valid     = 1'b0;
        bus.req_write     = 1'b0;
        bus.req_line_addr = '0;
        bus.req_wdata     = '0;

        // Reset state
        #2;
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_resp_valid", bus.resp_valid, 1'b0);
        check("rst_resp_err", bus.resp_err, 1'b0);
        check("rst_mem_valid", bus.mem_valid, 1'b0);
        check("rst_mem_we", bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 22'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 256'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Refill, zero-wait memory: hand-computed line 0xA02468A0 + 4k
        rd = '0;
        for (int k = 0; k < 8; k++) rd[32*k +: 32] = 32'hA024_68A0 + 32'(4 * k);
        n0 = resp_seen;
        issue(1'b0, 17'h1_2345, '0, 8, 1, 1'b0, rd, 17);
        wait_resp(n0 + 1, "refill_resp");

        // Writeback, line 1 -> addresses 0x20..0x3C
        wd = '0;
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'h1111_0000 + 32'(k);
        n0 = resp_seen;
        issue(1'b1, 17'h0_0001, wd, 8, 1, 1'b0, '0, 9);
        wait_resp(n0 + 1, "write_resp");

        // Backpressure: 3 stall cycles on beat 2 of a write
        wd = '0;
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'h2222_0000 + 32'(k);
        cfg_stall = 1; cfg_stall_beat = 3'd2; cfg_stall_len = 3; stall_done = 0;
        n0 = resp_seen;
        issue(1'b1, 17'h0_ABCD, wd, 8, 1, 1'b0, '0, 12);
        wait_resp(n0 + 1, "stall_resp");
        cfg_stall = 0;

        // Timeout: beat 5 of a read never returns data
        cfg_drop = 1; cfg_drop_beat = 3'd5;
        n0 = resp_seen;
        issue(1'b0, 17'h0_0100, '0, 6, 1, 1'b1, model_line(17'h0_0100, 5), -1);
        wait_resp(n0 + 1, "timeout_resp");
        cfg_drop = 0;

        // Normal write right after the aborted burst; resp_err must clear
        wd = '0;
        for (int k = 0; k < 8; k++) wd[32*k +: 32] = 32'h3333_0000 + 32'(k);
        n0 = resp_seen;
        issue(1'b1, 17'h0_0002, wd, 8, 1, 1'b0, '0, 9);
        wait_resp(n0 + 1, "post_timeout_resp");

        // Stray rvalid in IDLE and CMD cycles must be ignored
        cfg_stray = 1;
        repeat (3) @(posedge clk);
        n0 = resp_seen;
        issue(1'b0, 17'h1_FFFF, '0, 8, 1, 1'b0, model_line(17'h1_FFFF, 8), 17);
        wait_resp(n0 + 1, "stray_resp");
        cfg_stray = 0;

        // Reset during beat 3 of a refill: no response, fresh refill afterwards
        issue(1'b0, 17'h0_0ABC, '0, 3, 0, 1'b0, '0, -1);
        found = 0;
        for (int n = 0; n < 50 && !found; n++) begin
            @(posedge clk);
            #2;
            if (bus.mem_valid && bus.mem_addr[4:2] == 3'd3) begin
                found  = 1;
                resetn = 1'b0;
                #1;
                check("midrst_mem_valid", bus.mem_valid, 1'b0);
                check("midrst_resp_valid", bus.resp_valid, 1'b0);
                check("midrst_resp_rdata", bus.resp_rdata, 256'd0);
            end
        end
        if (!found) fail("midrst_beat3");
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("postrst_req_ready", bus.req_ready, 1'b1);
        repeat (3) @(negedge clk);

        rd = '0;
        for (int k = 0; k < 8; k++) rd[32*k +: 32] = 32'hA024_68A0 + 32'(4 * k);
        n0 = resp_seen;
        issue(1'b0, 17'h1_2345, '0, 8, 1, 1'b0, rd, 17);
        wait_resp(n0 + 1, "postrst_resp");

        repeat (5) @(negedge clk);
        check("cmd_q_empty", 256'(cmd_q.size()), 256'd0);
        check("resp_q_empty", 256'(resp_q.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cache_mem_port.md
Name: cache_mem_port

Overview:
- Memory-side companion to the direct-mapped cache. The cache hands this block a whole-line refill (read) or writeback (write) request.
- The block runs it as a word-serial burst of BLOCK_SIZE single-word transactions on a valid/ready memory bus.
- It returns the assembled 256-bit line, or a completion, in one response pulse.
- It sits between the cache line storage and the backing memory model or controller.

Parameters:
- ADDR_WIDTH, 22: byte-address width on the memory bus.
- WORD_SIZE, 32: bits per memory word.
- BLOCK_SIZE, 8: words per cache line; 32-byte line, 5 offset bits.
- LINE_ADDR_WIDTH, 17: line-address width, ADDR_WIDTH-5, i.e. {tag[8:0], index[7:0]}.
- TIMEOUT_CYCLES, 255: maximum cycles waited for any single mem_ready or mem_rvalid before aborting.

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  cache request strobe.
- req_ready  out  1  block idle and able to accept a request.
- req_write  in  1  1 = writeback line, 0 = refill line.
- req_line_addr  in  17  line address.
- req_wdata  in  256  line data for writeback; word k is bits [32k+31:32k].
- resp_valid  out  1  one-cycle completion pulse.
- resp_write  out  1  echo of the captured req_write, valid with resp_valid.
- resp_err  out  1  burst aborted on timeout, valid with resp_valid.
- resp_rdata  out  256  refilled line, valid with resp_valid on reads.
- mem_valid  out  1  memory command valid.
- mem_ready  in  1  memory accepts the command.
- mem_we  out  1  command is a write.
- mem_addr  out  22  byte address of the word.
- mem_wdata  out  32  write word.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, beat=0, timeout counter=0.
  - req_ready=1 (IDLE); resp_valid, resp_write, resp_err, mem_valid, mem_we = 0.
  - mem_addr, mem_wdata, resp_rdata = 0.
  - Reset mid-burst drops mem_valid at once and discards partial data; no response is issued.
- States: IDLE, CMD, RDATA, DONE. req_ready = (state==IDLE), combinational.
- IDLE:
  - On req_valid&&req_ready, capture req_write, req_line_addr and req_wdata; clear beat, resp_rdata and the timeout counter.
  - Go to CMD.
- CMD:
  - mem_valid=1, mem_we=captured write, mem_addr={line_addr, beat[2:0], 2'b00}.
  - mem_wdata = captured word[beat] on writes, 0 on reads.
  - Outputs are held stable until mem_ready.
  - On mem_valid&&mem_ready:
    - Write with beat==7: go to DONE.
    - Write with beat<7: beat+1, stay in CMD.
    - Read: go to RDATA.
- RDATA:
  - mem_valid=0.
  - On mem_rvalid: resp_rdata[32*beat +: 32] <= mem_rdata. If beat==7 go to DONE, else beat+1 and go to CMD.
- mem_rvalid is ignored outside RDATA, including the CMD handshake cycle; memory must return read data at least 1 cycle after the accept.
- Exactly one outstanding read at a time.
- Timeout:
  - The counter resets on every transition and increments each cycle spent in CMD or RDATA.
  - When it reaches TIMEOUT_CYCLES, abort: drop mem_valid, set resp_err=1, go to DONE.
  - resp_rdata keeps the words received so far; missing words are 0.
- DONE:
  - resp_valid=1 for exactly 1 cycle, with resp_write and resp_err.
  - Then go to IDLE; resp_err clears on the next accepted request.
- Latency, with zero-wait memory (mem_ready=1 always, rvalid 1 cycle after accept):
  - Write: accept cycle, 8 CMD cycles, then resp_valid at cycle 10.
  - Read: accept cycle, 8×(CMD+RDATA) = 16 cycles, then resp_valid at cycle 18.
- Back-to-back: earliest next accept is the cycle after DONE.
- req_valid while busy is not accepted; the requester must hold it.
- Beat counter is 3 bits: 7 is the last beat, no wrap past it.
- Addresses are always line-aligned plus the word offset; byte offset bits [1:0] are always 0.

Test Plan:
- Refill, zero-wait memory returning data = 0xA0000000|addr, line_addr=0x1_2345 → mem_addr sequence 0x2468A0, 0x2468A4 … 0x2468BC; resp_valid at cycle 18; resp_rdata word k = 0xA02468A0+4k; resp_err=0.
- Writeback, line_addr=0x0_0001, req_wdata word k = 0x1111_0000+k → 8 write commands at addresses 0x20–0x3C with matching mem_wdata; resp_valid at cycle 10 with resp_write=1.
- Backpressure: mem_ready low for 3 cycles on beat 2 of a write → mem_addr and mem_wdata stay stable while stalled; completion is delayed by exactly 3 cycles; no beat skipped or duplicated.
- Timeout: TIMEOUT_CYCLES=16, read where memory never asserts mem_rvalid on beat 5 → resp_valid with resp_err=1; words 0–4 hold data, words 5–7 are 0; next request is accepted normally.
- Reset mid-burst: assert resetn=0 during beat 3 of a refill → mem_valid falls the same cycle; no resp_valid; after release req_ready=1 and a fresh refill completes correctly.
- Stray mem_rvalid asserted during CMD and IDLE → ignored; resp_rdata and beat are unaffected.
